// File: rtl/sprite_blitter.sv
// Copies a sprite from its synchronous ROM into the 4-bit framebuffer at a signed
// screen position, with optional mirroring, transparency skip and screen clipping.
module sprite_blitter #(
  parameter int                SPR_W       = 64,
  parameter int                SPR_H       = 64,
  parameter int                SCR_W       = 640,
  parameter int                SCR_H       = 480,
  parameter int                DATA_W      = 4,
  parameter logic [DATA_W-1:0] TRANSPARENT = '0
) (
  input  logic                                      vga_clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic signed [10:0]                        pos_x,
  input  logic signed [10:0]                        pos_y,
  input  logic                                      mirror,
  output logic                                      busy,
  output logic                                      done,
  output logic [$clog2(SPR_W)+$clog2(SPR_H)-1:0]    rom_address,
  input  logic [DATA_W-1:0]                         rom_q,
  output logic [18:0]                               fb_addr,
  output logic [DATA_W-1:0]                         fb_data,
  output logic                                      fb_we,
  input  logic                                      fb_ready
);

  localparam int SX_W = $clog2(SPR_W);
  localparam int SY_W = $clog2(SPR_H);
  localparam logic signed [11:0] SCR_W_S = 12'(SCR_W);
  localparam logic signed [11:0] SCR_H_S = 12'(SCR_H);
  localparam logic [SX_W-1:0] SX_LAST = SX_W'(SPR_W - 1);
  localparam logic [SY_W-1:0] SY_LAST = SY_W'(SPR_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_READ, S_WRITE, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic signed [10:0]       px, py;
  logic                     mir;
  logic [SX_W-1:0]          sx;
  logic [SY_W-1:0]          sy;
  logic [SX_W-1:0]          src_col;
  logic signed [11:0]       dx, dy;
  logic                     clipped, last_px, advance, opaque;

  function automatic logic is_clipped(input logic signed [11:0] x, input logic signed [11:0] y);
    return x[11] || (x >= SCR_W_S) || y[11] || (y >= SCR_H_S);
  endfunction

  // Only called for on-screen pixels, so both coordinates are non-negative here.
  function automatic logic [18:0] fb_index(input logic signed [11:0] x, input logic signed [11:0] y);
    return 19'(y) * 19'(SCR_W) + 19'(x);
  endfunction

  // SPR_W is a power of two, so SPR_W-1-sx is the bitwise complement of sx.
  assign src_col     = mir ? ~sx : sx;
  assign rom_address = {sy, src_col};
  assign dx          = 12'(px) + 12'(sx);
  assign dy          = 12'(py) + 12'(sy);
  assign clipped     = is_clipped(dx, dy);
  assign last_px     = (sx == SX_LAST) && (sy == SY_LAST);
  assign opaque      = (rom_q != TRANSPARENT);
  assign advance     = ((state == S_FETCH) && clipped) ||
                       ((state == S_READ)  && !opaque) ||
                       ((state == S_WRITE) && fb_ready);

  always_ff @(posedge vga_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = clipped ? (last_px ? S_DONE : S_FETCH) : S_READ;
      S_READ:  state_nxt = opaque ? S_WRITE : (last_px ? S_DONE : S_FETCH);
      S_WRITE: if (fb_ready) state_nxt = last_px ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == S_FETCH) || (state == S_READ) || (state == S_WRITE);
    done  = (state == S_DONE);
    fb_we = (state == S_WRITE);
  end

  // Blit parameters, raster counters and the held framebuffer write.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      px      <= '0;
      py      <= '0;
      mir     <= 1'b0;
      sx      <= '0;
      sy      <= '0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        px  <= pos_x;
        py  <= pos_y;
        mir <= mirror;
        sx  <= '0;
        sy  <= '0;
      end else if (advance) begin
        sx <= sx + 1'b1;
        if (sx == SX_LAST) sy <= sy + 1'b1;
      end
      if ((state == S_READ) && opaque) begin
        fb_addr <= fb_index(dx, dy);
        fb_data <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model, write scoreboard and cycle-count checks.
module tb_sprite_blitter;

  logic               vga_clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               mirror = 1'b0;
  logic               fb_ready = 1'b1;
  logic signed [10:0] pos_x = '0;
  logic signed [10:0] pos_y = '0;
  logic               busy, done, fb_we;
  logic [11:0]        rom_address;
  logic [3:0]         rom_q;
  logic [3:0]         fb_data;
  logic [18:0]        fb_addr;

  sprite_blitter dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .start       (start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .mirror      (mirror),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .fb_ready    (fb_ready)
  );

  always #5 vga_clk = ~vga_clk;

  logic [3:0] rom_mem [0:4095];
  always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_count = 0;
  logic [18:0] first_addr = '0, last_addr = '0;
  logic [3:0]  first_data = '0, last_data = '0;
  logic [22:0] exp_q[$];
  logic        prev_we = 1'b0, prev_ready = 1'b0, prev_reset = 1'b1;
  logic [18:0] prev_addr = '0;
  logic [3:0]  prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Write monitor: a write is accepted on the next posedge when fb_we and fb_ready are both high.
  always @(negedge vga_clk) begin
    logic [22:0] e;
    if (prev_we && !prev_ready && !prev_reset)
      check("write_hold", {8'h0, fb_we, fb_addr, fb_data}, {8'h0, 1'b1, prev_addr, prev_data});
    if (fb_we && fb_ready && !reset) begin
      if (wr_count == 0) begin
        first_addr = fb_addr;
        first_data = fb_data;
      end
      last_addr = fb_addr;
      last_data = fb_data;
      wr_count++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr_data", {9'h0, fb_addr, fb_data}, {9'h0, e});
      end
    end
    prev_we    = fb_we;
    prev_ready = fb_ready;
    prev_reset = reset;
    prev_addr  = fb_addr;
    prev_data  = fb_data;
  end

  task automatic fill_rom(input int mode);
    for (int n = 0; n < 4096; n++) rom_mem[n] = (mode != 0) ? 4'(n) : 4'h5;
  endtask

  task automatic build_expected(input logic signed [10:0] x, input logic signed [10:0] y,
                                input logic m);
    int ex, ey, src;
    logic [3:0] d;
    exp_q.delete();
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        ex = int'(x) + c;
        ey = int'(y) + r;
        if (ex < 0 || ex >= 640 || ey < 0 || ey >= 480) continue;
        src = m ? 63 - c : c;
        d = rom_mem[r * 64 + src];
        if (d == 4'h0) continue;
        exp_q.push_back({19'(ey * 640 + ex), d});
      end
    end
  endtask

  task automatic run_blit(input string tag, input logic signed [10:0] x,
                          input logic signed [10:0] y, input logic m,
                          input int exp_cycles, input int exp_writes, input int bp_rel);
    int cnt;
    logic got;
    build_expected(x, y, m);
    wr_count = 0;
    fb_ready = (bp_rel == 0);
    @(posedge vga_clk); #1;
    pos_x = x; pos_y = y; mirror = m; start = 1'b1;
    @(posedge vga_clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    cnt = 0;
    got = 1'b0;
    while (cnt < 20000 && !got) begin
      @(posedge vga_clk); #1;
      cnt++;
      if (bp_rel != 0 && cnt == bp_rel) fb_ready = 1'b1;
      if (done) got = 1'b1;
    end
    check({tag, "_cycles"}, 32'(cnt), 32'(exp_cycles));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_writes"}, 32'(wr_count), 32'(exp_writes));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    @(posedge vga_clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    fb_ready = 1'b1;
  endtask

  initial begin
    int cnt;
    fill_rom(0);
    repeat (3) @(posedge vga_clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_rom_address", 32'(rom_address), 32'd0);
    reset = 1'b0;

    run_blit("opaque", 11'sd0, 11'sd0, 1'b0, 12288, 4096, 0);
    check("opaque_first_addr", 32'(first_addr), 32'd0);
    check("opaque_last_addr", 32'(last_addr), 32'd40383);
    check("opaque_first_data", 32'(first_data), 32'd5);
    check("opaque_last_data", 32'(last_data), 32'd5);

    fill_rom(1);
    run_blit("mirror", 11'sd100, 11'sd50, 1'b1, 3840 * 3 + 256 * 2, 3840, 0);
    check("mirror_first_addr", 32'(first_addr), 32'd32100);
    check("mirror_first_data", 32'(first_data), 32'd15);

    fill_rom(0);
    run_blit("partial", -11'sd10, 11'sd470, 1'b0, 540 * 3 + 3556, 540, 0);
    check("partial_first_addr", 32'(first_addr), 32'd300800);
    check("partial_last_addr", 32'(last_addr), 32'd306613);

    run_blit("offscreen", 11'sd700, 11'sd0, 1'b0, 4096, 0, 0);

    run_blit("backpressure", 11'sd600, 11'sd440, 1'b0, 1600 * 3 + 2496 + 5, 1600, 7);
    check("backpressure_first_addr", 32'(first_addr), 32'd282200);

    // Second start mid-blit, then reset while a write is pending.
    build_expected(11'sd0, 11'sd0, 1'b0);
    wr_count = 0;
    fb_ready = 1'b1;
    @(posedge vga_clk); #1;
    pos_x = 11'sd0; pos_y = 11'sd0; mirror = 1'b0; start = 1'b1;
    @(posedge vga_clk); #1;
    start = 1'b0;
    cnt = 0;
    while (cnt < 13) begin
      @(posedge vga_clk); #1;
      cnt++;
      if (cnt == 3) start = 1'b1;
      if (cnt == 4) start = 1'b0;
      if (cnt == 11) fb_ready = 1'b0;
    end
    check("midblit_we_pending", 32'(fb_we), 32'd1);
    check("midblit_writes", 32'(wr_count), 32'd3);
    check("midblit_addr_pending", 32'(fb_addr), 32'd3);
    reset = 1'b1;
    @(posedge vga_clk); #1;
    check("reset_fb_we", 32'(fb_we), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    exp_q.delete();
    fb_ready = 1'b1;
    @(posedge vga_clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge vga_clk);
    #1;
    check("after_reset_writes", 32'(wr_count), 32'd3);
    check("after_reset_busy", 32'(busy), 32'd0);

    run_blit("fresh", -11'sd60, -11'sd60, 1'b0, 16 * 3 + 4080, 16, 0);
    check("fresh_first_addr", 32'(first_addr), 32'd0);
    check("fresh_last_addr", 32'(last_addr), 32'd3 * 640 + 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Writes a 64×64 indexed-colour sprite from its sprite ROM into the 640×480 4-bit framebuffer at a signed screen position. It sits on the write side of the framebuffer; the display path reads the same palette indices back out and colours them.
- Optional horizontal mirroring for fighter facing direction.
- Transparent pixels are skipped.
- Off-screen pixels are clipped.
- Start/busy/done handshake toward the game logic and a ready-qualified write port toward the framebuffer arbiter.

## Interface
- SPR_W, 64: sprite width in pixels (power of two).
- SPR_H, 64: sprite height in pixels.
- SCR_W, 640: screen width.
- SCR_H, 480: screen height.
- TRANSPARENT, 4'h0: palette index that is never written.

Ports:
- vga_clk  input  1  sole clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- start  input  1  request a blit; sampled only in IDLE.
- pos_x  input  11  signed screen x of sprite left edge; latched on start.
- pos_y  input  11  signed screen y of sprite top edge; latched on start.
- mirror  input  1  1 = flip horizontally; latched on start.
- busy  output  1  blit in progress.
- done  output  1  one-cycle pulse when a blit completes.
- rom_address  output  12  sprite ROM address. Combinational from the counters; the ROM is synchronous with 1-cycle read latency.
- rom_q  input  4  ROM data, valid the cycle after its address.
- fb_addr  output  19  framebuffer word address, dy*SCR_W+dx.
- fb_data  output  4  palette index to write.
- fb_we  output  1  write request; held until accepted.
- fb_ready  input  1  arbiter accepts the write on any edge where fb_we=1 and fb_ready=1.

## Operation
- Latched on start: px, py, mir. Counters: sx (0..SPR_W-1) and sy (0..SPR_H-1), both cleared on start.
- Derived values:
  - src_col = mir ? SPR_W-1-sx : sx.
  - rom_address = sy*SPR_W + src_col.
  - dx = px+sx and dy = py+sy, as 12-bit signed values.
  - clipped = dx<0 or dx>=SCR_W or dy<0 or dy>=SCR_H.
- States:
  - IDLE: busy=0. start=1 latches inputs, clears counters and goes to FETCH.
  - FETCH: if clipped, ADVANCE directly with no ROM read. Otherwise rom_address is valid and the next state is READ.
  - READ: rom_q is valid. If rom_q==TRANSPARENT, ADVANCE. Otherwise register fb_addr and fb_data=rom_q, set fb_we=1 and go to WRITE.
  - WRITE: fb_we, fb_addr and fb_data stay stable. On an edge with fb_ready=1, clear fb_we and ADVANCE. Otherwise stay.
  - ADVANCE (a transition action, not a state): sx++. When sx wraps from SPR_W-1 to 0, sy++. If that was the last pixel (sx=SPR_W-1, sy=SPR_H-1), go to DONE; otherwise go to FETCH.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- busy=1 in FETCH, READ and WRITE.
- start is ignored outside IDLE; a request during a blit is dropped, not queued.
- Exactly one framebuffer write per opaque, on-screen sprite pixel, in raster order of destination (row-major, sy then sx).
- reset in any state:
  - Next state IDLE.
  - busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, counters 0.
  - A pending write is abandoned and no further writes occur.
- Reset values of all outputs:
  - busy, done and fb_we are 0.
  - fb_addr and fb_data are 0.
  - rom_address is 0, since counters are 0 and mir is 0.

## Timing
- The start-sampling edge is E0. The state is FETCH from E0 and busy=1 in the following cycle.
- Per-pixel cost with fb_ready tied 1:
  - opaque on-screen pixel: 3 cycles (FETCH, READ, WRITE).
  - transparent on-screen pixel: 2 cycles.
  - clipped pixel: 1 cycle.
- Each cycle fb_ready=0 in WRITE adds 1 cycle.
- done is high in the cycle that follows the last pixel's ADVANCE edge.
- A new start is accepted in the first IDLE cycle after done, so back-to-back blits have 2 dead cycles between them.
- fb_addr and fb_data must not change while fb_we=1.

## Test plan
- All-opaque ROM (every word 4'h5), pos (0,0), mirror=0, fb_ready=1:
  - 4096 writes; the first has fb_addr=0 and the last has fb_addr=63*640+63=40383, all with fb_data=5.
  - done is high in the cycle after edge E12288.
- ROM word n = n[3:0] (index 0 transparent), pos (100,50), mirror=1:
  - The write at dx=100, dy=50 carries the data of ROM address 63.
  - No write occurs for any ROM word with value 0.
  - Write count is 3840.
- Partial clip, pos (-10,470), opaque ROM:
  - Only sx 10..63 and sy 0..9 are written, 540 writes.
  - The first write has fb_addr=470*640+0; none has dx<0 or dy>479.
  - Blit cycle count is 540*3+3556.
- Fully off-screen, pos (700,0):
  - Zero writes and ROM never read.
  - done after exactly 4096 cycles.
- Backpressure: fb_ready low for 5 cycles on the first write:
  - fb_we, fb_addr and fb_data stay stable throughout.
  - A single write is accepted, and done is delayed by exactly 5 cycles.
- start pulsed again mid-blit, then reset asserted mid-WRITE:
  - The second start is ignored.
  - After reset: fb_we=0, busy=0 and done=0 on the next cycle, and no further writes.
  - A fresh start then blits normally.
